riscv_reset_sequencer: RTL and testbench
========================================

# riscv_reset_sequencer

Parametrised multi-channel reset sequencer for the RISC-V platform. It takes the single board-level reset and produces one active-high reset per downstream channel (core, data memory, instruction memory, peripherals). Channels are held for a programmable pulse width, then released one at a time with a programmable stagger. After the power-on sequence completes, each channel can be re-reset individually on software request. It sits between the top-level reset input and the `rst_i` pins of `riscv_sc_top` and its sibling blocks.

## Interface

Parameters:
- NUM_CH, 4, number of reset channels (≥1)
- PULSE_W, 4, cycles each reset is held (≥1)
- STAGGER, 2, cycles between successive channel releases (≥0; 0 means all channels release together)
- CNTW, $clog2(PULSE_W + NUM_CH*STAGGER + 1), counter width (derived; do not override)

Ports:
- clk_i  in  1  clock, rising edge
- rst_i  in  1  one clock; reset is synchronous and active-low
- hold_i  in  1  while 1, freezes the sequence counter in ASSERT and RELEASE
- sw_req_i  in  NUM_CH  per-channel software reset request, sampled each edge
- ch_rst_o  out  NUM_CH  active-high channel resets, registered
- sw_busy_o  out  NUM_CH  channel k is in a software-requested reset
- done_o  out  1  power-on sequence complete, registered
- seq_state_o  out  2  ASSERT=2'd0, RELEASE=2'd1, DONE=2'd2

## Operation

- Reset values (any edge with rst_i=0): state ASSERT, counter 0, ch_rst_o all 1s, sw_busy_o 0, done_o 0, per-channel software counters 0.
- ASSERT: counter increments on each edge with hold_i=0. When the count reaches PULSE_W, ch_rst_o[0] clears. If NUM_CH=1 or STAGGER=0, all channels clear and the state goes to DONE; otherwise the state goes to RELEASE.
- RELEASE: counter keeps incrementing while hold_i=0. ch_rst_o[k] clears on the edge where the count equals PULSE_W + k*STAGGER. The state goes to DONE on the edge that clears ch_rst_o[NUM_CH-1]. Released channels stay released while hold_i=1.
- DONE: done_o=1 and the global counter stops. If sw_req_i[k]=1 on an edge:
  - ch_rst_o[k] and sw_busy_o[k] are set.
  - Per-channel counter k loads PULSE_W, then decrements each edge. hold_i has no effect here.
  - When counter k reaches 0, ch_rst_o[k] and sw_busy_o[k] clear on that same edge.
- Retrigger: sw_req_i[k]=1 while sw_busy_o[k]=1 reloads counter k with PULSE_W, extending the pulse.
- Channels run independently; requests on several channels in the same cycle are all accepted.
- sw_req_i is ignored (dropped, not latched) in ASSERT and RELEASE.
- done_o stays 1 during software resets.
- seq_state_o never returns from DONE to ASSERT except through rst_i=0.
- Counter arithmetic is unsigned, CNTW bits wide. The widest comparison, PULSE_W+(NUM_CH-1)*STAGGER, fits in CNTW, so the counter never wraps.

## Timing

- E1 is the first rising edge that samples rst_i=1 and hold_i=0. Edges are numbered counting only those with hold_i=0.
- ch_rst_o[k] falls immediately after edge PULSE_W + k*STAGGER.
- done_o rises after the same edge as the last channel release.
- Software reset: request sampled at edge R → ch_rst_o[k] high after R, falls after edge R+PULSE_W. The pulse is exactly PULSE_W cycles.
- rst_i=0 mid-sequence or mid software reset: all outputs return to reset values after that edge, and the sequence restarts from E1.
- Outputs have no combinational path from inputs; all are registered.

## Test plan

- Defaults (NUM_CH=4, PULSE_W=4, STAGGER=2): release rst_i → ch_rst_o goes 1111→1110 after edge 4, 1100 after 6, 1000 after 8, 0000 after 10. done_o=1 and seq_state_o=2 after edge 10.
- hold_i=1 for 3 cycles starting after edge 5 → ch1 release delayed from edge 6 to wall-clock edge 9. ch0 stays 0 throughout.
- STAGGER=0 → all four channels fall together after edge 4. RELEASE is skipped (state goes 0→2).
- In DONE, pulse sw_req_i=4'b0100 for one cycle → ch_rst_o[2]=1 for exactly 4 cycles, sw_busy_o[2] tracks it, done_o stays 1. Repeat the request after 2 cycles → total pulse is 6 cycles.
- sw_req_i=4'b1111 held during RELEASE → ignored, sequence timing unchanged. Assert sw_req_i[1], sw_req_i[3] in the same DONE cycle → both channels pulse for 4 cycles.
- rst_i=0 for one edge at edge 7 of the sequence, and again during a software reset → ch_rst_o=1111, done_o=0, sw_busy_o=0, state 0 on the next cycle. A full resequence follows.

Source files
------------

// File: rtl/riscv_reset_sequencer.sv
// riscv_reset_sequencer
//
// Turns the single board-level reset into NUM_CH active-high channel resets.
// After reset every channel is held for PULSE_W counted cycles, then the
// channels are released one by one, STAGGER cycles apart. Once the power-on
// sequence is DONE, each channel can be re-reset for PULSE_W cycles on a
// software request.
//
// Ports:
//   clk_i        clock, rising edge
//   rst_i        synchronous active-low reset
//   hold_i       freezes the power-on sequence counter while high
//   sw_req_i     per-channel software reset request (honoured only in DONE)
//   ch_rst_o     registered active-high channel resets
//   sw_busy_o    channel is in a software-requested reset
//   done_o       power-on sequence complete (registered)
//   seq_state_o  0 = ASSERT, 1 = RELEASE, 2 = DONE
module riscv_reset_sequencer #(
  parameter int unsigned NUM_CH  = 4,
  parameter int unsigned PULSE_W = 4,
  parameter int unsigned STAGGER = 2,
  parameter int unsigned CNTW    = $clog2(PULSE_W + NUM_CH * STAGGER + 1)
) (
  input  logic              clk_i,
  input  logic              rst_i,
  input  logic              hold_i,
  input  logic [NUM_CH-1:0] sw_req_i,
  output logic [NUM_CH-1:0] ch_rst_o,
  output logic [NUM_CH-1:0] sw_busy_o,
  output logic              done_o,
  output logic [1:0]        seq_state_o
);

  typedef enum logic [1:0] {
    StAssert  = 2'd0,
    StRelease = 2'd1,
    StDone    = 2'd2
  } seq_state_e;

  localparam logic [CNTW-1:0] PulseW  = CNTW'(PULSE_W);
  // Count at which the last channel releases; equals PulseW when STAGGER=0
  // or NUM_CH=1, which makes ASSERT go straight to DONE.
  localparam logic [CNTW-1:0] LastRel = CNTW'(PULSE_W + (NUM_CH - 1) * STAGGER);

  seq_state_e                     state_q, state_d;
  logic [CNTW-1:0]                cnt_q, cnt_d, cnt_inc;
  logic [NUM_CH-1:0]              ch_rst_q, ch_rst_d;
  logic [NUM_CH-1:0]              busy_q, busy_d;
  logic                           done_q, done_d;
  logic [NUM_CH-1:0][CNTW-1:0]    sw_cnt_q, sw_cnt_d;

  always_comb begin
    state_d  = state_q;
    cnt_d    = cnt_q;
    ch_rst_d = ch_rst_q;
    busy_d   = busy_q;
    done_d   = done_q;
    sw_cnt_d = sw_cnt_q;
    cnt_inc  = cnt_q + CNTW'(1);

    unique case (state_q)
      StAssert, StRelease: begin
        // Software requests are dropped here, not latched.
        if (!hold_i) begin
          cnt_d = cnt_inc;
          for (int unsigned k = 0; k < NUM_CH; k++) begin
            if (cnt_inc == CNTW'(PULSE_W + k * STAGGER)) begin
              ch_rst_d[k] = 1'b0;
            end
          end
          if (cnt_inc == LastRel) begin
            state_d = StDone;
            done_d  = 1'b1;
          end else if (state_q == StAssert && cnt_inc == PulseW) begin
            state_d = StRelease;
          end
        end
      end
      StDone: begin
        for (int unsigned k = 0; k < NUM_CH; k++) begin
          if (sw_req_i[k]) begin
            // New request or retrigger: (re)load the full pulse width.
            ch_rst_d[k] = 1'b1;
            busy_d[k]   = 1'b1;
            sw_cnt_d[k] = PulseW;
          end else if (busy_q[k]) begin
            sw_cnt_d[k] = sw_cnt_q[k] - CNTW'(1);
            if (sw_cnt_q[k] == CNTW'(1)) begin
              ch_rst_d[k] = 1'b0;
              busy_d[k]   = 1'b0;
            end
          end
        end
      end
      default: begin
        state_d = StAssert;
      end
    endcase
  end

  always_ff @(posedge clk_i) begin
    if (!rst_i) begin
      state_q  <= StAssert;
      cnt_q    <= '0;
      ch_rst_q <= '1;
      busy_q   <= '0;
      done_q   <= 1'b0;
      sw_cnt_q <= '0;
    end else begin
      state_q  <= state_d;
      cnt_q    <= cnt_d;
      ch_rst_q <= ch_rst_d;
      busy_q   <= busy_d;
      done_q   <= done_d;
      sw_cnt_q <= sw_cnt_d;
    end
  end

  assign ch_rst_o    = ch_rst_q;
  assign sw_busy_o   = busy_q;
  assign done_o      = done_q;
  assign seq_state_o = state_q;

endmodule

// File: tb/tb_riscv_reset_sequencer.sv
// Directed bench for riscv_reset_sequencer: default instance plus a
// STAGGER=0 instance sharing the same stimulus.
module tb_riscv_reset_sequencer;

  logic       clk = 1'b0;
  logic       rst_n;
  logic       hold;
  logic [3:0] sw_req;

  logic [3:0] ch_rst, busy;
  logic       done;
  logic [1:0] state;
  logic [3:0] ch_rst_s0, busy_s0;
  logic       done_s0;
  logic [1:0] state_s0;

  int n_cmp = 0;
  int n_err = 0;

  always #5 clk = ~clk;

  riscv_reset_sequencer u_dut (
    .clk_i       (clk),
    .rst_i       (rst_n),
    .hold_i      (hold),
    .sw_req_i    (sw_req),
    .ch_rst_o    (ch_rst),
    .sw_busy_o   (busy),
    .done_o      (done),
    .seq_state_o (state)
  );

  riscv_reset_sequencer #(
    .NUM_CH  (4),
    .PULSE_W (4),
    .STAGGER (0)
  ) u_dut_s0 (
    .clk_i       (clk),
    .rst_i       (rst_n),
    .hold_i      (hold),
    .sw_req_i    (sw_req),
    .ch_rst_o    (ch_rst_s0),
    .sw_busy_o   (busy_s0),
    .done_o      (done_s0),
    .seq_state_o (state_s0)
  );

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_cmp++;
    if (got !== exp) begin
      n_err++;
      $display("FAIL %s: got %0h expected %0h", tag, got, exp);
    end
  endtask

  // One rising edge; inputs change and outputs are sampled 1 time unit later.
  task automatic step();
    @(posedge clk);
    #1;
  endtask

  // Expected ch_rst after logical edge n of the default power-on sequence.
  function automatic logic [3:0] exp_rst(input int n);
    logic [3:0] v;
    for (int k = 0; k < 4; k++) v[k] = (n < 4 + 2 * k);
    return v;
  endfunction

  task automatic check_reset_vals(input string tag);
    check({tag, "_rst"}, ch_rst, 4'b1111);
    check({tag, "_busy"}, busy, 4'b0000);
    check({tag, "_done"}, done, 1'b0);
    check({tag, "_state"}, state, 2'd0);
  endtask

  // Runs a full default sequence from E1 and checks every edge.
  task automatic full_sequence(input string tag);
    for (int n = 1; n <= 10; n++) begin
      step();
      check($sformatf("%s_e%0d", tag, n), ch_rst, exp_rst(n));
    end
    check({tag, "_done"}, done, 1'b1);
    check({tag, "_state"}, state, 2'd2);
  endtask

  initial begin
    rst_n  = 1'b0;
    hold   = 1'b0;
    sw_req = 4'b0000;
    step();
    step();
    check_reset_vals("por");
    check("por_s0_rst", ch_rst_s0, 4'b1111);

    // Power-on sequence; sw_req=1111 held during RELEASE must be ignored.
    rst_n = 1'b1;
    for (int n = 1; n <= 10; n++) begin
      step();
      check($sformatf("seq_e%0d", n), ch_rst, exp_rst(n));
      check($sformatf("seq_busy_e%0d", n), busy, 4'b0000);
      if (n == 3) begin
        check("s0_e3_rst", ch_rst_s0, 4'b1111);
        check("s0_e3_state", state_s0, 2'd0);
      end
      if (n == 4) begin
        check("seq_e4_state", state, 2'd1);
        check("seq_e4_done", done, 1'b0);
        check("s0_e4_rst", ch_rst_s0, 4'b0000);
        check("s0_e4_state", state_s0, 2'd2);
        check("s0_e4_done", done_s0, 1'b1);
        sw_req = 4'b1111;
      end
      if (n == 5) begin
        // STAGGER=0 instance is already DONE and accepts the request.
        check("s0_e5_busy", busy_s0, 4'b1111);
        check("s0_e5_rst", ch_rst_s0, 4'b1111);
        check("s0_e5_done", done_s0, 1'b1);
      end
      if (n == 9) check("seq_e9_state", state, 2'd1);
    end
    sw_req = 4'b0000;
    check("seq_done", done, 1'b1);
    check("seq_state", state, 2'd2);
    step();

    // Single software pulse on ch2, then a retrigger 2 cycles in.
    sw_req = 4'b0100;
    for (int i = 0; i <= 4; i++) begin
      step();
      sw_req = 4'b0000;
      check($sformatf("sw1_rst_%0d", i), ch_rst, (i < 4) ? 4'b0100 : 4'b0000);
      check($sformatf("sw1_busy_%0d", i), busy, (i < 4) ? 4'b0100 : 4'b0000);
      check($sformatf("sw1_done_%0d", i), done, 1'b1);
    end
    sw_req = 4'b0100;
    for (int i = 0; i <= 6; i++) begin
      step();
      sw_req = (i == 1) ? 4'b0100 : 4'b0000;
      check($sformatf("sw2_rst_%0d", i), ch_rst, (i < 6) ? 4'b0100 : 4'b0000);
      check($sformatf("sw2_busy_%0d", i), busy, (i < 6) ? 4'b0100 : 4'b0000);
    end

    // Two channels requested in the same cycle.
    sw_req = 4'b1010;
    for (int i = 0; i <= 4; i++) begin
      step();
      sw_req = 4'b0000;
      check($sformatf("sw3_rst_%0d", i), ch_rst, (i < 4) ? 4'b1010 : 4'b0000);
      check($sformatf("sw3_busy_%0d", i), busy, (i < 4) ? 4'b1010 : 4'b0000);
    end
    check("sw3_state", state, 2'd2);

    // Restart, then hold for 3 wall edges after logical edge 5.
    rst_n = 1'b0;
    step();
    check_reset_vals("rst1");
    rst_n = 1'b1;
    for (int n = 1; n <= 5; n++) step();
    check("hold_e5", ch_rst, 4'b1110);
    hold = 1'b1;
    for (int w = 6; w <= 8; w++) begin
      step();
      check($sformatf("hold_w%0d", w), ch_rst, 4'b1110);
      check($sformatf("hold_state_w%0d", w), state, 2'd1);
    end
    hold = 1'b0;
    step();
    check("hold_w9", ch_rst, 4'b1100);

    // Reset at logical edge 7, then a full resequence.
    rst_n = 1'b0;
    step();
    check_reset_vals("rst_mid");
    rst_n = 1'b1;
    full_sequence("reseq1");

    // Reset during a software pulse, then a full resequence.
    sw_req = 4'b0001;
    step();
    sw_req = 4'b0000;
    check("sw4_busy", busy, 4'b0001);
    step();
    rst_n = 1'b0;
    step();
    check_reset_vals("rst_sw");
    rst_n = 1'b1;
    full_sequence("reseq2");

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

endmodule
